// File: rtl/sha2_pkg.sv
// sha2_pkg: shared SHA-2 constants (round K tables, Sigma rotation amounts) and the
// compression FSM state type.
package sha2_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    // Sigma0 / Sigma1 rotation triples, indexed [sigma][term]
    localparam int SIG256 [2][3] = '{'{2, 13, 22}, '{6, 11, 25}};
    localparam int SIG512 [2][3] = '{'{28, 34, 39}, '{14, 18, 41}};

    function automatic int sig_rot(input int w, input int s, input int t);
        return (w == 32) ? SIG256[s][t] : SIG512[s][t];
    endfunction

    localparam logic [31:0] K256 [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [63:0] K512 [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

endpackage

// File: rtl/sha2_round.sv
// sha2_round: one combinational SHA-2 round (Sigma0, Sigma1, Ch, Maj) producing the
// shifted working variables a..h for either word width.
module sha2_round import sha2_pkg::*; #(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    input  logic [WORD_W-1:0] i_c,
    input  logic [WORD_W-1:0] i_d,
    input  logic [WORD_W-1:0] i_e,
    input  logic [WORD_W-1:0] i_f,
    input  logic [WORD_W-1:0] i_g,
    input  logic [WORD_W-1:0] i_h,
    input  logic [WORD_W-1:0] i_k,
    input  logic [WORD_W-1:0] i_w,
    output logic [WORD_W-1:0] o_a,
    output logic [WORD_W-1:0] o_b,
    output logic [WORD_W-1:0] o_c,
    output logic [WORD_W-1:0] o_d,
    output logic [WORD_W-1:0] o_e,
    output logic [WORD_W-1:0] o_f,
    output logic [WORD_W-1:0] o_g,
    output logic [WORD_W-1:0] o_h
);

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int r);
        return (x >> r) | (x << (WORD_W - r));
    endfunction

    logic [WORD_W-1:0] w_s0, w_s1, w_ch, w_maj, w_t1, w_t2;

    always_comb begin
        w_s0  = rotr(i_a, sig_rot(WORD_W, 0, 0)) ^ rotr(i_a, sig_rot(WORD_W, 0, 1)) ^ rotr(i_a, sig_rot(WORD_W, 0, 2));
        w_s1  = rotr(i_e, sig_rot(WORD_W, 1, 0)) ^ rotr(i_e, sig_rot(WORD_W, 1, 1)) ^ rotr(i_e, sig_rot(WORD_W, 1, 2));
        w_ch  = (i_e & i_f) ^ (~i_e & i_g);
        w_maj = (i_a & i_b) ^ (i_a & i_c) ^ (i_b & i_c);
        w_t1  = i_h + w_s1 + w_ch + i_k + i_w;
        w_t2  = w_s0 + w_maj;
    end

    assign o_a = w_t1 + w_t2;
    assign o_b = i_a;
    assign o_c = i_b;
    assign o_d = i_c;
    assign o_e = i_d + w_t1;
    assign o_f = i_e;
    assign o_g = i_f;
    assign o_h = i_g;

endmodule

// File: rtl/sha2_compress_core.sv
// sha2_compress_core: SHA-256/512 compression engine consuming one schedule word per round
// and returning H + working variables. Optional `abort` port via SHA2_CMP_ABORT_EN.
module sha2_compress_core import sha2_pkg::*; #(
    parameter int  WORD_W = 32,
    localparam int ROUNDS = (WORD_W == 64) ? 80 : 64
) (
    input  logic                CLK,
    input  logic                RESET_N,
`ifdef SHA2_CMP_ABORT_EN
    input  logic                abort,
`endif
    input  logic                start,
    input  logic [8*WORD_W-1:0] h_in,
    input  logic                w_valid,
    output logic                w_ready,
    input  logic [WORD_W-1:0]   w_data,
    output logic                busy,
    output logic                dig_valid,
    input  logic                dig_ready,
    output logic [8*WORD_W-1:0] digest
);

    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
        $error("sha2_compress_core: WORD_W must be 32 or 64");
    end

    state_t              r_state, w_next;
    logic [6:0]          r_rnd;
    logic [WORD_W-1:0]   r_hv [8];
    logic [WORD_W-1:0]   r_v [8];
    logic [WORD_W-1:0]   w_hin [8];
    logic [WORD_W-1:0]   w_nv [8];
    logic [WORD_W-1:0]   w_k;
    logic [8*WORD_W-1:0] w_sum, r_digest;
    logic                w_abort, w_start, w_fire, w_last;

`ifdef SHA2_CMP_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_start = (r_state == IDLE) && start;
    assign w_fire  = (r_state == ROUND) && w_valid;
    assign w_last  = w_fire && (r_rnd == 7'(ROUNDS - 1));

    // Word 0 (H0 / a) sits in the MSBs of both h_in and digest
    for (genvar i = 0; i < 8; i++) begin : g_word
        assign w_hin[i] = h_in[(7-i)*WORD_W +: WORD_W];
        assign w_sum[(7-i)*WORD_W +: WORD_W] = r_hv[i] + w_nv[i];
    end

    if (WORD_W == 32) begin : g_k256
        assign w_k = K256[r_rnd[5:0]];
    end else begin : g_k512
        assign w_k = K512[r_rnd];
    end

    sha2_round #(.WORD_W(WORD_W)) u_round (
        .i_a(r_v[0]), .i_b(r_v[1]), .i_c(r_v[2]), .i_d(r_v[3]),
        .i_e(r_v[4]), .i_f(r_v[5]), .i_g(r_v[6]), .i_h(r_v[7]),
        .i_k(w_k), .i_w(w_data),
        .o_a(w_nv[0]), .o_b(w_nv[1]), .o_c(w_nv[2]), .o_d(w_nv[3]),
        .o_e(w_nv[4]), .o_f(w_nv[5]), .o_g(w_nv[6]), .o_h(w_nv[7])
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_abort)                           w_next = IDLE;
        else if (w_start)                      w_next = ROUND;
        else if (w_last)                       w_next = DONE;
        else if (r_state == DONE && dig_ready) w_next = IDLE;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rnd    <= '0;
            r_hv     <= '{default: '0};
            r_v      <= '{default: '0};
            r_digest <= '0;
        end else if (w_abort) begin
            r_rnd    <= '0;
            r_v      <= '{default: '0};
            r_digest <= '0;
        end else if (w_start) begin
            r_rnd <= '0;
            r_hv  <= w_hin;
            r_v   <= w_hin;
        end else if (w_fire) begin
            r_v   <= w_nv;
            r_rnd <= w_last ? '0 : r_rnd + 7'd1;
            if (w_last) r_digest <= w_sum;
        end
    end

    assign w_ready   = (r_state == ROUND);
    assign busy      = (r_state != IDLE);
    assign dig_valid = (r_state == DONE);
    assign digest    = r_digest;

endmodule

// File: tb/tb_sha2_compress_core.sv
// tb_sha2_compress_core: drives a SHA-256 and a SHA-512 instance with known-answer and
// random blocks, checking digests and timing against a plain-arithmetic SHA-2 model.
module tb_sha2_compress_core;
    import sha2_pkg::*;

    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;

    logic         start32 = 0, start64 = 0, w_valid = 0, dig_ready = 0, abort = 0, sel = 0;
    logic [511:0] h_in = '0;
    logic [63:0]  w_data = '0;
    logic         wr32, wr64, busy32, busy64, dv32, dv64;
    logic [255:0] dg32;
    logic [511:0] dg64, last_dig;
    logic         wr, bsy, dv;
    logic [511:0] dg;

    assign wr  = sel ? wr64 : wr32;
    assign bsy = sel ? busy64 : busy32;
    assign dv  = sel ? dv64 : dv32;
    assign dg  = sel ? dg64 : {256'b0, dg32};

    sha2_compress_core #(.WORD_W(32)) u32 (
        .CLK(clk), .RESET_N(rst_n),
`ifdef SHA2_CMP_ABORT_EN
        .abort(abort),
`endif
        .start(start32), .h_in(h_in[255:0]), .w_valid(w_valid), .w_ready(wr32),
        .w_data(w_data[31:0]), .busy(busy32), .dig_valid(dv32), .dig_ready(dig_ready), .digest(dg32)
    );

    sha2_compress_core #(.WORD_W(64)) u64 (
        .CLK(clk), .RESET_N(rst_n),
`ifdef SHA2_CMP_ABORT_EN
        .abort(abort),
`endif
        .start(start64), .h_in(h_in), .w_valid(w_valid), .w_ready(wr64),
        .w_data(w_data), .busy(busy64), .dig_valid(dv64), .dig_ready(dig_ready), .digest(dg64)
    );

    int tests = 0, fails = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    localparam logic [63:0] IV512 [8] = '{
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    logic [63:0] mh [8];
    logic [63:0] mw [80];
    logic [63:0] md [8];

    function automatic logic [63:0] msk(input int n);
        return (n == 32) ? 64'hffff_ffff : '1;
    endfunction

    function automatic logic [63:0] rr(input logic [63:0] x, input int r, input int n);
        return ((x >> r) | (x << (n - r))) & msk(n);
    endfunction

    // Message expansion W[16..] from W[0..15]
    function automatic void sched(input int n);
        logic [63:0] s0, s1;
        for (int t = 16; t < 80; t++) begin
            s0 = (n == 32) ? rr(mw[t-15], 7, n) ^ rr(mw[t-15], 18, n) ^ (mw[t-15] >> 3)
                           : rr(mw[t-15], 1, n) ^ rr(mw[t-15], 8, n) ^ (mw[t-15] >> 7);
            s1 = (n == 32) ? rr(mw[t-2], 17, n) ^ rr(mw[t-2], 19, n) ^ (mw[t-2] >> 10)
                           : rr(mw[t-2], 19, n) ^ rr(mw[t-2], 61, n) ^ (mw[t-2] >> 6);
            mw[t] = (s1 + mw[t-7] + s0 + mw[t-16]) & msk(n);
        end
    endfunction

    function automatic void model(input int n);
        logic [63:0] v [8];
        logic [63:0] k, t1, t2, bs0, bs1, ch, maj;
        for (int j = 0; j < 8; j++) v[j] = mh[j];
        for (int t = 0; t < ((n == 32) ? 64 : 80); t++) begin
            k   = (n == 32) ? (K512[t] >> 32) : K512[t];
            bs1 = (n == 32) ? rr(v[4], 6, n) ^ rr(v[4], 11, n) ^ rr(v[4], 25, n)
                            : rr(v[4], 14, n) ^ rr(v[4], 18, n) ^ rr(v[4], 41, n);
            bs0 = (n == 32) ? rr(v[0], 2, n) ^ rr(v[0], 13, n) ^ rr(v[0], 22, n)
                            : rr(v[0], 28, n) ^ rr(v[0], 34, n) ^ rr(v[0], 39, n);
            ch  = (v[4] & v[5]) ^ (~v[4] & v[6]);
            maj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
            t1  = (v[7] + bs1 + ch + k + mw[t]) & msk(n);
            t2  = (bs0 + maj) & msk(n);
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = (v[4] + t1) & msk(n);
            v[0] = (t1 + t2) & msk(n);
        end
        for (int j = 0; j < 8; j++) md[j] = (mh[j] + v[j]) & msk(n);
    endfunction

    task automatic set_abc(input bit s);
        for (int j = 0; j < 8; j++) mh[j] = s ? IV512[j] : (IV512[j] >> 32);
        for (int j = 0; j < 80; j++) mw[j] = '0;
        mw[0]  = s ? 64'h6162638000000000 : 64'h61626380;
        mw[15] = 64'h18;
    endtask

    task automatic set_rand(input bit s);
        for (int j = 0; j < 8; j++) mh[j] = {$urandom, $urandom} & msk(s ? 64 : 32);
        for (int j = 0; j < 16; j++) mw[j] = {$urandom, $urandom} & msk(s ? 64 : 32);
    endtask

    // Runs one block; cut >= 0 interrupts it after that many W handshakes (reset or abort)
    task automatic run_block(input bit s, input logic [79:0] gap, input int hold, input bit st_done,
                             input int cut, input bit cut_abort, input string tag);
        int n, lat, idx, exp_lat;
        bit sk, done, hs;
        logic [511:0] exp;
        n = s ? 64 : 32;
        sched(n);
        model(n);
        exp = '0;
        h_in = '0;
        for (int j = 0; j < 8; j++) begin
            if (s) begin h_in[(7-j)*64 +: 64] = mh[j]; exp[(7-j)*64 +: 64] = md[j]; end
            else   begin h_in[(7-j)*32 +: 32] = mh[j][31:0]; exp[(7-j)*32 +: 32] = md[j][31:0]; end
        end
        exp_lat = (s ? 81 : 65) + $countones(gap);
        sel = s;
        @(negedge clk);
        if (s) start64 = 1; else start32 = 1;
        @(posedge clk);
        lat = 1; idx = 0; sk = 0; done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            start32 = 0; start64 = 0;
            if (dv) done = 1;
            else if (cut >= 0 && idx == cut) begin
                if (!cut_abort) begin
                    #2 rst_n = 0;
                    #1;
                    chk({tag, " busy after reset"}, 512'(bsy), 512'(0));
                    chk({tag, " w_ready after reset"}, 512'(wr), 512'(0));
                    chk({tag, " dig_valid after reset"}, 512'(dv), 512'(0));
                    chk({tag, " digest after reset"}, dg, '0);
                    @(negedge clk);
                    rst_n = 1; w_valid = 0;
                end else begin
                    abort = 1; w_valid = 1; w_data = mw[idx];
                    if (s) start64 = 1; else start32 = 1;
                    @(negedge clk);
                    abort = 0; w_valid = 0; start32 = 0; start64 = 0;
                    chk({tag, " busy after abort"}, 512'(bsy), 512'(0));
                    chk({tag, " w_ready after abort"}, 512'(wr), 512'(0));
                    chk({tag, " digest after abort"}, dg, '0);
                    repeat (3) begin
                        @(negedge clk);
                        chk({tag, " dig_valid after abort"}, 512'(dv), 512'(0));
                    end
                end
                return;
            end else begin
                w_valid = !(gap[idx] && !sk);
                sk = gap[idx] && !sk;
                w_data = mw[idx];
                hs = wr && w_valid;
                @(posedge clk);
                lat++;
                if (hs) idx++;
            end
        end
        w_valid = 0;
        chk({tag, " reached dig_valid"}, 512'(done), 512'(1));
        chk({tag, " latency"}, 512'(lat), 512'(exp_lat));
        chk({tag, " digest"}, dg, exp);
        last_dig = dg;
        for (int c = 0; c < hold; c++) begin
            if (st_done) begin if (s) start64 = 1; else start32 = 1; end
            @(negedge clk);
            chk({tag, " dig_valid held"}, 512'(dv), 512'(1));
            chk({tag, " digest held"}, dg, exp);
        end
        dig_ready = 1;
        @(negedge clk);
        dig_ready = 0; start32 = 0; start64 = 0;
        chk({tag, " busy after handshake"}, 512'(bsy), 512'(0));
        chk({tag, " dig_valid after handshake"}, 512'(dv), 512'(0));
    endtask

    initial begin
        #1;
        chk("reset busy32", 512'(busy32), 512'(0));
        chk("reset w_ready32", 512'(wr32), 512'(0));
        chk("reset dig_valid32", 512'(dv32), 512'(0));
        chk("reset digest32", 512'(dg32), '0);
        chk("reset busy64", 512'(busy64), 512'(0));
        chk("reset dig_valid64", 512'(dv64), 512'(0));
        chk("reset digest64", dg64, '0);
        @(negedge clk);
        rst_n = 1;

        set_abc(0);
        run_block(0, '0, 0, 0, -1, 0, "abc256");
        chk("abc256 known digest", last_dig,
            512'h_ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

        set_abc(1);
        run_block(1, '0, 0, 0, -1, 0, "abc512");
        chk("abc512 digest head", 512'(last_dig[511:448]), 512'(64'hddaf35a193617aba));
        chk("abc512 digest tail", 512'(last_dig[31:0]), 512'(32'ha54ca49f));

        set_abc(0);
        run_block(0, (80'd1 << 0) | (80'd1 << 17) | (80'd1 << 63), 0, 0, -1, 0, "abc256 gaps");
        chk("abc256 gaps known digest", last_dig,
            512'h_ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

        set_abc(0);
        run_block(0, '0, 10, 1, -1, 0, "abc256 hold");

        set_abc(0);
        run_block(0, '0, 0, 0, 30, 0, "reset r30");
        set_abc(0);
        run_block(0, '0, 0, 0, -1, 0, "abc256 after reset");
        chk("abc256 after reset known", last_dig,
            512'h_ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

        for (int r = 0; r < 4; r++) begin
            set_rand(0);
            run_block(0, {16'b0, $urandom & $urandom, $urandom & $urandom}, r, r[0], -1, 0, "rand256");
        end
        for (int r = 0; r < 2; r++) begin
            set_rand(1);
            run_block(1, {$urandom & $urandom & 16'hffff, $urandom & $urandom, $urandom & $urandom},
                      r, 0, -1, 0, "rand512");
        end

`ifdef SHA2_CMP_ABORT_EN
        set_abc(0);
        run_block(0, '0, 0, 0, 40, 1, "abort r40");
        set_abc(0);
        run_block(0, '0, 0, 0, -1, 0, "abc256 after abort");
        chk("abc256 after abort known", last_dig,
            512'h_ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sha2_compress_core.md
# sha2_compress_core

Parametrised SHA-2 compression engine that supersedes the fixed SHA-256 round datapath. WORD_W selects SHA-256 (32-bit words, 64 rounds) or SHA-512 (64-bit words, 80 rounds). The core accepts one schedule word per round over a valid/ready stream and sequences its own rounds with an internal counter. It performs the final feed-forward addition itself and returns the digest over a valid/ready handshake. It sits between the message-schedule block and the top-level hash controller.

## Interface
- WORD_W, 32, word width; legal values 32 (SHA-256) or 64 (SHA-512); any other value is an elaboration error
- ROUNDS, derived (64 when WORD_W=32, 80 when WORD_W=64), not overridable
- CLK  in  1  single clock; all state updates on posedge only
- RESET_N  in  1  asynchronous, active-low reset
- start  in  1  pulse; captures h_in and begins a block; honoured only in IDLE
- h_in  in  8*WORD_W  chaining value H0..H7, H0 in the MSBs
- w_valid  in  1  schedule word valid
- w_ready  out  1  core can consume a schedule word this cycle
- w_data  in  WORD_W  schedule word W[rnd]
- busy  out  1  state != IDLE
- dig_valid  out  1  digest valid
- dig_ready  in  1  consumer accepts the digest
- digest  out  8*WORD_W  H' = H + working variables, H'0 in the MSBs

## Operation
- States: IDLE, ROUND, DONE.
- IDLE, start=1:
  - Latch h_in into the H register and into working registers a..h.
  - Set rnd to 0 and go to ROUND.
- ROUND:
  - w_ready=1.
  - On each w_valid&w_ready, apply one round combinationally in the same cycle: T1 = h+Σ1(e)+Ch(e,f,g)+K[rnd]+w_data and T2 = Σ0(a)+Maj(a,b,c).
  - Shift the working registers, then rnd++.
  - Cycles with w_valid=0 leave all state unchanged.
- Final round (handshake when rnd==ROUNDS-1):
  - Register digest = H + updated working variables, computed per word and taken mod 2^WORD_W.
  - Go to DONE.
- DONE:
  - dig_valid=1 and w_ready=0.
  - digest is held stable until dig_valid&dig_ready, then the core goes to IDLE.
  - A start asserted in DONE, including on the handshake cycle, is ignored.
- start while busy is ignored; h_in is not re-sampled.
- Arithmetic: all additions wrap modulo 2^WORD_W; no carries leave a word.
- Σ rotations:
  - SHA-256: Σ0 = (2,13,22), Σ1 = (6,11,25).
  - SHA-512: Σ0 = (28,34,39), Σ1 = (14,18,41).
- K source: K256[0..63] when WORD_W=32, K512[0..79] when WORD_W=64.

## Timing
- Reset values:
  - state IDLE, rnd 0.
  - H and a..h all 0; digest 0.
  - w_ready 0, dig_valid 0, busy 0.
- Reset is asynchronous at any point, including mid-ROUND or mid-DONE. It aborts the block with no digest produced.
- start accepted at edge n: busy=1 and w_ready=1 from cycle n+1.
- Minimum block latency is ROUNDS+1 cycles from the start edge to dig_valid, with w_valid held continuously high.
- Each w_valid gap of k cycles adds exactly k cycles of latency.
- dig_valid rises the cycle after the final W handshake.
- After the dig_ready handshake edge, busy=0 and the next start is accepted one cycle later at the earliest.

## Configuration
- SHA2_CMP_ABORT_EN defined:
  - Adds an input port `abort` (1 bit).
  - abort=1 in any state forces IDLE at the next edge and clears dig_valid, rnd, a..h and digest.
  - abort has priority over start, the W handshake and the digest handshake in the same cycle.
- SHA2_CMP_ABORT_EN undefined: the port is absent and the only way to terminate a block is RESET_N.

## Structure
- Package sha2_pkg holds:
  - K256 and K512 constant arrays.
  - Σ rotation constants per width.
  - The state enum {IDLE, ROUND, DONE}.
- Sub-module sha2_round (purely combinational, parameter WORD_W):
  - Inputs: a..h, K, W.
  - Outputs: next a..h.
  - Contains Σ0, Σ1, Ch and Maj.
- The top module contains the FSM, round counter, registers, K mux and feed-forward adders.

## Test plan
- WORD_W=32, SHA-256 IV, schedule of padded "abc", w_valid always 1 -> dig_valid at start+65 cycles; digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- WORD_W=64, SHA-512 IV, schedule of padded "abc" -> dig_valid at start+81 cycles; digest begins ddaf35a193617aba and ends a54ca49f.
- SHA-256 "abc" with w_valid deasserted on rounds 0, 17 and 63 (one cycle each) -> same digest, latency 68 cycles.
- dig_ready held low 10 cycles, with start pulsed during DONE -> digest and dig_valid stable; start ignored; IDLE only after the dig_ready handshake.
- RESET_N pulsed low at round 30 -> all outputs 0 immediately; a following clean "abc" block yields the correct digest.
- SHA2_CMP_ABORT_EN: abort at round 40, with start asserted in the same cycle -> IDLE next cycle, busy=0, dig_valid never asserted.
